alt_eyemon_dprio_arb: RTL and testbench

ALT_EYEMON_DPRIO_ARB -- requirements
Module: alt_eyemon_dprio_arb

---
 rtl/alt_eyemon_dprio_arb.sv | 200 ++++++++++++++++++++
 tb/tb_alt_eyemon_dprio_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_eyemon_dprio_arb.sv
// Two-port round-robin arbiter that serialises DPRIO read/write requests onto one alt_dprio master.
// Optional WAIT_DONE timeout with sticky o_timeout: define ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN.
module alt_eyemon_dprio_arb #(
  parameter int DPRIO_ADDR_WIDTH  = 16,
  parameter int DPRIO_DATA_WIDTH  = 16,
  parameter int BUSY_START_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                        i_avmm_clk,
  input  logic                        i_reset,
  input  logic                        i_rq0_wren,
  input  logic                        i_rq0_rden,
  input  logic [DPRIO_ADDR_WIDTH-1:0] i_rq0_addr,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_rq0_data,
  output logic                        o_rq0_busy,
  output logic [DPRIO_DATA_WIDTH-1:0] o_rq0_dataout,
  output logic                        o_rq0_rdvalid,
  input  logic                        i_rq1_wren,
  input  logic                        i_rq1_rden,
  input  logic [DPRIO_ADDR_WIDTH-1:0] i_rq1_addr,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_rq1_data,
  output logic                        o_rq1_busy,
  output logic [DPRIO_DATA_WIDTH-1:0] o_rq1_dataout,
  output logic                        o_rq1_rdvalid,
  output logic                        o_dprio_wren,
  output logic                        o_dprio_rden,
  output logic [DPRIO_ADDR_WIDTH-1:0] o_dprio_addr,
  output logic [DPRIO_DATA_WIDTH-1:0] o_dprio_data,
  input  logic                        i_dprio_busy,
  input  logic [DPRIO_DATA_WIDTH-1:0] i_dprio_in,
  output logic                        o_arb_busy
`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
  ,
  output logic                        o_timeout
`endif
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > BUSY_START_CYCLES) ? TIMEOUT_CYCLES : BUSY_START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg;
  logic                        grant_reg, grant_next, last_reg;
  logic                        op_wr_reg;
  logic [DPRIO_ADDR_WIDTH-1:0] addr_reg;
  logic [DPRIO_DATA_WIDTH-1:0] data_reg;
  logic                        do_grant, complete, timed_out;
  logic [DPRIO_DATA_WIDTH-1:0] rd_word;

  logic [1:0]                  req_any, req_wr, pend_valid, pend_wr, rdvalid;
  logic [DPRIO_ADDR_WIDTH-1:0] req_addr [2];
  logic [DPRIO_DATA_WIDTH-1:0] req_data [2];
  logic [DPRIO_ADDR_WIDTH-1:0] pend_addr [2];
  logic [DPRIO_DATA_WIDTH-1:0] pend_data [2];
  logic [DPRIO_DATA_WIDTH-1:0] dataout [2];

  assign req_any     = {i_rq1_wren | i_rq1_rden, i_rq0_wren | i_rq0_rden};
  assign req_wr      = {i_rq1_wren, i_rq0_wren};
  assign req_addr[0] = i_rq0_addr;
  assign req_addr[1] = i_rq1_addr;
  assign req_data[0] = i_rq0_data;
  assign req_data[1] = i_rq1_data;

  // A timed-out read returns all-ones so software can tell it from real data.
  assign rd_word = timed_out ? {DPRIO_DATA_WIDTH{1'b1}} : i_dprio_in;

  // Per-port one-deep pending slot and read-return registers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                        valid_reg, wr_reg, rdvalid_reg;
    logic [DPRIO_ADDR_WIDTH-1:0] paddr_reg;
    logic [DPRIO_DATA_WIDTH-1:0] pdata_reg, dout_reg;
    logic                        done_here;

    assign done_here = complete && (grant_reg == 1'(gi));

    always_ff @(posedge i_avmm_clk) begin
      if (i_reset) begin
        valid_reg   <= 1'b0;
        wr_reg      <= 1'b0;
        paddr_reg   <= '0;
        pdata_reg   <= '0;
        dout_reg    <= '0;
        rdvalid_reg <= 1'b0;
      end else begin
        if (req_any[gi] && !valid_reg) begin
          valid_reg <= 1'b1;
          wr_reg    <= req_wr[gi];
          paddr_reg <= req_addr[gi];
          pdata_reg <= req_data[gi];
        end else if (done_here) begin
          valid_reg <= 1'b0;
        end
        rdvalid_reg <= done_here && !op_wr_reg;
        if (done_here && !op_wr_reg) dout_reg <= rd_word;
      end
    end

    assign pend_valid[gi] = valid_reg;
    assign pend_wr[gi]    = wr_reg;
    assign pend_addr[gi]  = paddr_reg;
    assign pend_data[gi]  = pdata_reg;
    assign dataout[gi]    = dout_reg;
    assign rdvalid[gi]    = rdvalid_reg;
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    do_grant   = 1'b0;
    complete   = 1'b0;
    timed_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|pend_valid) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
          grant_next = (&pend_valid) ? ~last_reg : pend_valid[1];
        end
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (i_dprio_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == CNT_W'(BUSY_START_CYCLES - 1)) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!i_dprio_busy) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          complete   = 1'b1;
          timed_out  = 1'b1;
          state_next = IDLE;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_avmm_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;
      op_wr_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT_BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
      else if (state_reg == WAIT_DONE) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
`endif
      if (do_grant) begin
        grant_reg <= grant_next;
        last_reg  <= grant_next;
        op_wr_reg <= pend_wr[grant_next];
        addr_reg  <= pend_addr[grant_next];
        data_reg  <= pend_data[grant_next];
      end
    end
  end

`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
  logic timeout_reg;
  always_ff @(posedge i_avmm_clk) begin
    if (i_reset)        timeout_reg <= 1'b0;
    else if (timed_out) timeout_reg <= 1'b1;
  end
  assign o_timeout = timeout_reg;
`endif

  assign o_dprio_wren  = (state_reg == ISSUE) && op_wr_reg;
  assign o_dprio_rden  = (state_reg == ISSUE) && !op_wr_reg;
  assign o_dprio_addr  = addr_reg;
  assign o_dprio_data  = data_reg;
  assign o_rq0_busy    = pend_valid[0];
  assign o_rq1_busy    = pend_valid[1];
  assign o_arb_busy    = |pend_valid;
  assign o_rq0_dataout = dataout[0];
  assign o_rq1_dataout = dataout[1];
  assign o_rq0_rdvalid = rdvalid[0];
  assign o_rq1_rdvalid = rdvalid[1];

endmodule

// File: tb/tb_alt_eyemon_dprio_arb.sv
// Self-checking bench for alt_eyemon_dprio_arb: vector table, scoreboard queues and a simple alt_dprio responder.
module tb_alt_eyemon_dprio_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic        i_rq0_wren, i_rq0_rden, i_rq1_wren, i_rq1_rden;
  logic [15:0] i_rq0_addr, i_rq0_data, i_rq1_addr, i_rq1_data;
  logic        o_rq0_busy, o_rq1_busy, o_rq0_rdvalid, o_rq1_rdvalid;
  logic [15:0] o_rq0_dataout, o_rq1_dataout;
  logic        o_dprio_wren, o_dprio_rden;
  logic [15:0] o_dprio_addr, o_dprio_data;
  logic        i_dprio_busy;
  logic [15:0] i_dprio_in;
  logic        o_arb_busy;
`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
  logic        o_timeout;
`endif

  alt_eyemon_dprio_arb #(
    .DPRIO_ADDR_WIDTH(16), .DPRIO_DATA_WIDTH(16),
    .BUSY_START_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_avmm_clk(clk), .i_reset(i_reset),
    .i_rq0_wren(i_rq0_wren), .i_rq0_rden(i_rq0_rden), .i_rq0_addr(i_rq0_addr), .i_rq0_data(i_rq0_data),
    .o_rq0_busy(o_rq0_busy), .o_rq0_dataout(o_rq0_dataout), .o_rq0_rdvalid(o_rq0_rdvalid),
    .i_rq1_wren(i_rq1_wren), .i_rq1_rden(i_rq1_rden), .i_rq1_addr(i_rq1_addr), .i_rq1_data(i_rq1_data),
    .o_rq1_busy(o_rq1_busy), .o_rq1_dataout(o_rq1_dataout), .o_rq1_rdvalid(o_rq1_rdvalid),
    .o_dprio_wren(o_dprio_wren), .o_dprio_rden(o_dprio_rden),
    .o_dprio_addr(o_dprio_addr), .o_dprio_data(o_dprio_data),
    .i_dprio_busy(i_dprio_busy), .i_dprio_in(i_dprio_in),
    .o_arb_busy(o_arb_busy)
`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  typedef struct {
    bit          port;
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] data;
    int          busy_len;
    bit          exp_rdv;
    logic [15:0] exp_dout;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } iss_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          issue_cyc = 0;
  int          slave_busy_len = 2;
  bit          mon_en = 1'b0;
  bit          prev_pulse = 1'b0;
  bit          last_exp = 1'b1;
  logic [15:0] last_dout [2];
  iss_t        iss_q [$];
  logic [15:0] rd_q0 [$];
  logic [15:0] rd_q1 [$];
  iss_t        iss_e;
  logic [15:0] rd_e;
  vec_t        vt [7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] slave_rdata(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hC3C3);
  endfunction

  task automatic exp_issue(input bit wr, input logic [15:0] a, input logic [15:0] d);
    iss_q.push_back('{wr: wr, addr: a, data: d});
  endtask

  // alt_dprio stand-in: raises busy right after a command for slave_busy_len cycles, then returns data.
  initial begin
    i_dprio_busy = 1'b0;
    i_dprio_in   = '0;
    forever begin
      @(posedge clk); #1;
      if (o_dprio_wren === 1'b1 || o_dprio_rden === 1'b1) begin
        if (slave_busy_len > 0) begin
          i_dprio_busy = 1'b1;
          repeat (slave_busy_len) @(posedge clk);
          #1;
        end
        i_dprio_in   = slave_rdata(o_dprio_addr);
        i_dprio_busy = 1'b0;
      end
    end
  end

  // Scoreboard side: every DPRIO command and every read return is matched against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_dprio_wren === 1'b1 || o_dprio_rden === 1'b1) begin
        $display("[TB] issue %s addr=0x%04h data=0x%04h cycle=%0d",
                 o_dprio_wren ? "WR" : "RD", o_dprio_addr, o_dprio_data, cyc);
        check("no_back_to_back", prev_pulse, 1'b0);
        check("issue_expected", iss_q.size() != 0, 1'b1);
        if (iss_q.size() != 0) begin
          iss_e = iss_q.pop_front();
          check("issue_wren", o_dprio_wren, iss_e.wr);
          check("issue_rden", o_dprio_rden, !iss_e.wr);
          check("issue_addr", o_dprio_addr, iss_e.addr);
          check("issue_data", o_dprio_data, iss_e.data);
        end
        issue_cyc  = cyc;
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
      end
      if (o_rq0_rdvalid === 1'b1) begin
        $display("[TB] rq0 read return 0x%04h", o_rq0_dataout);
        check("rq0_rdvalid_expected", rd_q0.size() != 0, 1'b1);
        if (rd_q0.size() != 0) begin
          rd_e = rd_q0.pop_front();
          check("rq0_dataout", o_rq0_dataout, rd_e);
        end
      end
      if (o_rq1_rdvalid === 1'b1) begin
        $display("[TB] rq1 read return 0x%04h", o_rq1_dataout);
        check("rq1_rdvalid_expected", rd_q1.size() != 0, 1'b1);
        if (rd_q1.size() != 0) begin
          rd_e = rd_q1.pop_front();
          check("rq1_dataout", o_rq1_dataout, rd_e);
        end
      end
    end
  end

  task automatic drive_req(input bit p, input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    if (!p) begin
      i_rq0_wren = wr; i_rq0_rden = rd; i_rq0_addr = a; i_rq0_data = d;
    end else begin
      i_rq1_wren = wr; i_rq1_rden = rd; i_rq1_addr = a; i_rq1_data = d;
    end
    @(posedge clk); #1;
    i_rq0_wren = 1'b0; i_rq0_rden = 1'b0; i_rq1_wren = 1'b0; i_rq1_rden = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (o_arb_busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_bound", n < limit, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rq0_busy"}, o_rq0_busy, 1'b0);
    check({tag, "_rq1_busy"}, o_rq1_busy, 1'b0);
    check({tag, "_arb_busy"}, o_arb_busy, 1'b0);
    check({tag, "_dprio_cmd"}, {o_dprio_wren, o_dprio_rden}, 2'b00);
    check({tag, "_dprio_addr"}, o_dprio_addr, 16'h0);
    check({tag, "_dprio_data"}, o_dprio_data, 16'h0);
    check({tag, "_rq0_dataout"}, o_rq0_dataout, 16'h0);
    check({tag, "_rq1_dataout"}, o_rq1_dataout, 16'h0);
    check({tag, "_rdvalid"}, {o_rq0_rdvalid, o_rq1_rdvalid}, 2'b00);
  endtask

  initial begin
    int n;
    bit first;
    vt[0] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'hA5A5, 3, 1'b0, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 3, 1'b1, 16'hBEEF};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 2, 1'b1, 16'hC2C3};
    vt[3] = '{1'b1, 1'b1, 1'b0, 16'h2222, 16'h7777, 5, 1'b0, 16'h0000};
    vt[4] = '{1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 0, 1'b1, 16'hBEEF};
    vt[5] = '{1'b1, 1'b1, 1'b1, 16'h3333, 16'h1111, 2, 1'b0, 16'h0000};
    vt[6] = '{1'b1, 1'b0, 1'b1, 16'h00FF, 16'h0000, 4, 1'b1, 16'hC33C};
    last_dout[0] = 16'h0;
    last_dout[1] = 16'h0;

    i_reset = 1'b1;
    i_rq0_wren = 1'b0; i_rq0_rden = 1'b0; i_rq0_addr = '0; i_rq0_data = '0;
    i_rq1_wren = 1'b0; i_rq1_rden = 1'b0; i_rq1_addr = '0; i_rq1_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    i_reset = 1'b0;
    mon_en  = 1'b1;

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) begin
      slave_busy_len = vt[i].busy_len;
      exp_issue(vt[i].wr, vt[i].addr, vt[i].data);
      if (vt[i].exp_rdv) begin
        if (vt[i].port) rd_q1.push_back(vt[i].exp_dout);
        else            rd_q0.push_back(vt[i].exp_dout);
      end
      drive_req(vt[i].port, vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data);
      @(negedge clk);
      check("vec_busy_set", vt[i].port ? o_rq1_busy : o_rq0_busy, 1'b1);
      wait_idle(100);
      if (vt[i].exp_rdv) last_dout[vt[i].port] = vt[i].exp_dout;
      check("vec_dataout_after", vt[i].port ? o_rq1_dataout : o_rq0_dataout, last_dout[vt[i].port]);
      last_exp = vt[i].port;
    end

    // Busy never rises: ISSUE, four WAIT_BUSY cycles, then idle.
    slave_busy_len = 0;
    exp_issue(1'b0, 16'h0200, 16'h0000);
    rd_q0.push_back(16'hC1C3);
    drive_req(1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000);
    wait_idle(100);
    check("no_busy_turnaround", cyc - issue_cyc, 5);
    check("no_busy_dataout", o_rq0_dataout, 16'hC1C3);
    last_exp = 1'b0;

    // A second pulse while the port is busy must be ignored.
    slave_busy_len = 3;
    exp_issue(1'b1, 16'h0C00, 16'h3333);
    drive_req(1'b0, 1'b1, 1'b0, 16'h0C00, 16'h3333);
    drive_req(1'b0, 1'b0, 1'b1, 16'h0D00, 16'h0000);
    @(negedge clk);
    check("ignored_pulse_busy", o_rq0_busy, 1'b1);
    wait_idle(100);
    repeat (12) @(negedge clk);
    check("ignored_pulse_no_issue", iss_q.size(), 0);

    // Reset in the middle of WAIT_DONE, with rq1 also pending.
    slave_busy_len = 20;
    exp_issue(1'b0, 16'h0E00, 16'h0000);
    drive_req(1'b0, 1'b0, 1'b1, 16'h0E00, 16'h0000);
    drive_req(1'b1, 1'b1, 1'b0, 16'h0F00, 16'h4444);
    repeat (4) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    last_dout[0] = 16'h0;
    last_dout[1] = 16'h0;
    n = 0;
    while (i_dprio_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("slave_released", i_dprio_busy, 1'b0);
    check("midreset_no_issue", iss_q.size(), 0);
    slave_busy_len = 2;
    exp_issue(1'b0, 16'h0040, 16'h0000);
    rd_q0.push_back(16'hBEEF);
    drive_req(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000);
    wait_idle(100);
    check("post_reset_read", o_rq0_dataout, 16'hBEEF);
    check("post_reset_rq1_idle", o_rq1_busy, 1'b0);
    last_exp = 1'b0;

    // Simultaneous requests twice from a fresh reset: port 0 wins first, then alternation.
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    last_exp = 1'b1;
    slave_busy_len = 2;
    repeat (2) begin
      first = !last_exp;
      exp_issue(1'b1, first ? 16'h0B00 : 16'h0A00, first ? 16'h2000 : 16'h1000);
      exp_issue(1'b1, first ? 16'h0A00 : 16'h0B00, first ? 16'h1000 : 16'h2000);
      @(posedge clk); #1;
      i_rq0_wren = 1'b1; i_rq0_addr = 16'h0A00; i_rq0_data = 16'h1000;
      i_rq1_wren = 1'b1; i_rq1_addr = 16'h0B00; i_rq1_data = 16'h2000;
      @(posedge clk); #1;
      i_rq0_wren = 1'b0; i_rq1_wren = 1'b0;
      @(negedge clk);
      check("tie_both_busy", {o_rq0_busy, o_rq1_busy}, 2'b11);
      wait_idle(200);
      last_exp = !first;
    end

`ifdef ALT_EYEMON_DPRIO_ARB_TIMEOUT_EN
    check("timeout_clear_before", o_timeout, 1'b0);
    slave_busy_len = 60;
    exp_issue(1'b0, 16'h0060, 16'h0000);
    rd_q0.push_back(16'hFFFF);
    drive_req(1'b0, 1'b0, 1'b1, 16'h0060, 16'h0000);
    wait_idle(100);
    check("timeout_read_ones", o_rq0_dataout, 16'hFFFF);
    check("timeout_set", o_timeout, 1'b1);
    repeat (5) @(negedge clk);
    check("timeout_sticky", o_timeout, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("issue_queue_drained", iss_q.size(), 0);
    check("rd0_queue_drained", rd_q0.size(), 0);
    check("rd1_queue_drained", rd_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
